rv32im_ifu: RTL

Instruction fetch unit for the rv32im core. Owns the fetch PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake. Buffers returned instructions with their PCs in a small prefetch FIFO and presents them to decode with a valid/ready handshake. Consumes the branch unit's redirect (target PC) and flushes wrong-path fetches.

---
 rtl/rv32im_ifu_pkg.sv | 15 +
 rtl/rv32im_ifu_fifo.sv | 60 ++++++
 rtl/rv32im_ifu.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rv32im_ifu_pkg.sv
// Shared constants and state encoding for the rv32im instruction fetch unit.
package rv32im_ifu_pkg;

  localparam int          API_ADDR_WIDTH = 32;
  localparam int          API_DATA_WIDTH = 32;
  localparam logic [31:0] API_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] RV_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_ST_IDLE = 2'd0,
    IFU_ST_WAIT = 2'd1,
    IFU_ST_DROP = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/rv32im_ifu_fifo.sv
// Prefetch FIFO of {pc, instr} pairs; flush wins over push, pop of empty is ignored.
module rv32im_ifu_fifo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        push_pc_i,
  input  logic [DATA_W-1:0]        push_instr_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [ADDR_W-1:0]        head_pc_o,
  output logic [DATA_W-1:0]        head_instr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign count_o      = count_q;
  assign head_pc_o    = pc_mem[rd_ptr_q];
  assign head_instr_o = instr_mem[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is not reset; occupancy lives in the pointers/count, so stale words are never visible.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      pc_mem[wr_ptr_q]    <= push_pc_i;
      instr_mem[wr_ptr_q] <= push_instr_i;
    end
  end

endmodule

// File: rtl/rv32im_ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps at most one imem fetch in flight,
// buffers responses for decode and squashes wrong-path fetches on redirect.
module rv32im_ifu
  import rv32im_ifu_pkg::*;
#(
  parameter int                ADDR_W     = API_ADDR_WIDTH,
  parameter int                DATA_W     = API_DATA_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(API_RESET_PC),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i,
  output logic              misaligned_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              misaligned_q, misaligned_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_instr;

  logic [CNT_W:0]    slots_used;
  logic              in_flight, space, pop, push, grant;

  rv32im_ifu_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_pc_i    (req_pc_q),
    .push_instr_i (imem_rdata_i),
    .pop_i        (pop),
    .flush_i      (redirect_i),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .count_o      (fifo_count),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? DATA_W'(RV_NOP) : head_instr;
  assign instr_pc_o    = fifo_empty ? '0 : head_pc;
  assign imem_addr_o   = fetch_pc_q;
  assign misaligned_o  = misaligned_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    misaligned_d = misaligned_q;

    pop       = instr_valid_o && instr_ready_i && !redirect_i;
    in_flight = (state_q == IFU_ST_WAIT);
    push      = in_flight && imem_rvalid_i && !redirect_i;

    // The in-flight response keeps its reserved slot; an entry leaving this cycle
    // frees one, which is what sustains one fetch per cycle into a shallow buffer.
    slots_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(in_flight) - (CNT_W+1)'(pop);
    space      = (!fifo_full || pop) && (slots_used < (CNT_W+1)'(FIFO_DEPTH));

    imem_req_o = !rst_i && !redirect_i && !misaligned_q && space &&
                 ((state_q == IFU_ST_IDLE) || (in_flight && imem_rvalid_i));
    grant      = imem_req_o && imem_gnt_i;

    case (state_q)
      IFU_ST_IDLE: if (grant) state_d = IFU_ST_WAIT;
      IFU_ST_WAIT: begin
        if (imem_rvalid_i)   state_d = grant ? IFU_ST_WAIT : IFU_ST_IDLE;
        else if (redirect_i) state_d = IFU_ST_DROP;
      end
      IFU_ST_DROP: if (imem_rvalid_i) state_d = IFU_ST_IDLE;
      default:     state_d = IFU_ST_IDLE;
    endcase

    if (grant) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end

    if (redirect_i) begin
      fetch_pc_d   = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      misaligned_d = |redirect_pc_i[1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IFU_ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule
